// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises the bus, checks start/parity/stop, strobes bytes.
// Optional ps2_clk glitch filter is compiled in with `define PS2_RX_FILTER_EN.
module ps2_rx_frame #(
  parameter int TIMEOUT_COUNT = 5000,
  parameter int BIT_WIDTH     = 13,
  parameter int FILTER_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       inhibit,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       reset_required
);

  // state  | meaning
  // IDLE   | waiting for a start bit
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking the stop bit and reporting the frame
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [BIT_WIDTH-1:0] TMO_LAST = BIT_WIDTH'(TIMEOUT_COUNT - 1);

  if (FILTER_LEN < 1 || TIMEOUT_COUNT < 1 || (TIMEOUT_COUNT >> BIT_WIDTH) != 0) begin : g_bad_cfg
    $error("ps2_rx_frame: bad parameters (FILTER_LEN >= 1, 2**BIT_WIDTH > TIMEOUT_COUNT >= 1)");
  end

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_lvl;
  logic       data_lvl;
  logic       clk_prev;
  logic       fall;
  logic       data_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

`ifdef PS2_RX_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0]        filt_cnt;
  logic                  filt_lvl;
  logic [FILTER_LEN-1:0] data_dly;

  // Data is delayed by the same amount as the filter so it stays aligned with its clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b1;
      data_dly <= '1;
    end else begin
      data_dly[0] <= data_sync[1];
      for (int i = 1; i < FILTER_LEN; i++) begin
        data_dly[i] <= data_dly[i-1];
      end
      if (clk_sync[1] == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_lvl <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign clk_lvl  = filt_lvl;
  assign data_lvl = data_dly[FILTER_LEN-1];
`else
  assign clk_lvl  = clk_sync[1];
  assign data_lvl = data_sync[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_prev <= 1'b1;
      fall     <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      clk_prev <= clk_lvl;
      fall     <= clk_prev & ~clk_lvl;
      data_bit <= data_lvl;
    end
  end

  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic [BIT_WIDTH-1:0] tmo_q, tmo_d;
  logic [7:0]           data_d;
  logic                 dv_d, pe_d, fe_d, rr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      par_q          <= 1'b0;
      tmo_q          <= '0;
      data           <= '0;
      data_valid     <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      reset_required <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      par_q          <= par_d;
      tmo_q          <= tmo_d;
      data           <= data_d;
      data_valid     <= dv_d;
      parity_err     <= pe_d;
      frame_err      <= fe_d;
      reset_required <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    data_d    = data;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    rr_d      = 1'b0;

    if (inhibit) begin
      state_d = IDLE;
      tmo_d   = '0;
    end else begin
      if (state_q != IDLE) begin
        tmo_d = fall ? '0 : tmo_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (fall) begin
            if (!data_bit) begin
              state_d   = DATA;
              shift_d   = '0;
              bit_cnt_d = '0;
            end else begin
              fe_d = 1'b1;
            end
          end
        end
        DATA: begin
          if (fall) begin
            shift_d   = {data_bit, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par_d   = data_bit;
            state_d = STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_d = IDLE;
            if (!data_bit) begin
              fe_d = 1'b1;
            end else if (^{shift_q, par_q}) begin
              data_d = shift_q;
              dv_d   = 1'b1;
              rr_d   = (shift_q == 8'hAA);
            end else begin
              pe_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A fall in the same cycle keeps the frame alive, so only a quiet bus times out.
      if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
        fe_d    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: drives raw PS/2 frames and compares every cycle against a frame-level model.
module tb_ps2_rx_frame;
  localparam int T  = 200;
  localparam int BW = 8;
  localparam int FL = 4;
  localparam int H  = 20;
`ifdef PS2_RX_FILTER_EN
  localparam int LAT = 4 + FL;
`else
  localparam int LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       inhibit = 1'b0;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, reset_required;

  ps2_rx_frame #(.TIMEOUT_COUNT(T), .BIT_WIDTH(BW), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .inhibit(inhibit),
    .data(data), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .reset_required(reset_required)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       dv;
    logic       pe;
    logic       fe;
    logic       rr;
    logic [7:0] b;
  } ev_t;

  ev_t        q[$];
  logic [7:0] m_data = 8'h00;
  int         n_chk = 0, n_pass = 0;
  int         cnt_dv = 0, cnt_pe = 0, cnt_fe = 0, cnt_rr = 0;
  int         last_fall = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    logic e_dv, e_pe, e_fe, e_rr;
    e_dv = 1'b0; e_pe = 1'b0; e_fe = 1'b0; e_rr = 1'b0;
    if (!rst) begin
      q.delete();
      m_data = 8'h00;
    end else if (q.size() > 0 && q[0].at == cyc) begin
      e_dv = q[0].dv; e_pe = q[0].pe; e_fe = q[0].fe; e_rr = q[0].rr;
      if (q[0].dv) m_data = q[0].b;
      void'(q.pop_front());
    end
    chk("data_valid", {7'b0, data_valid}, {7'b0, e_dv});
    chk("parity_err", {7'b0, parity_err}, {7'b0, e_pe});
    chk("frame_err", {7'b0, frame_err}, {7'b0, e_fe});
    chk("reset_required", {7'b0, reset_required}, {7'b0, e_rr});
    chk("data", data, m_data);
    cnt_dv += int'(data_valid);
    cnt_pe += int'(parity_err);
    cnt_fe += int'(frame_err);
    cnt_rr += int'(reset_required);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic dv, input logic pe, input logic fe,
                           input logic rr, input logic [7:0] b);
    ev_t e;
    e.at = at; e.dv = dv; e.pe = pe; e.fe = fe; e.rr = rr; e.b = b;
    q.push_back(e);
  endtask

  task automatic fall_edge(input logic b);
    ps2_data = b;
    tick(H);
    ps2_clk   = 1'b0;
    last_fall = cyc;
  endtask

  task automatic rise_edge();
    tick(H);
    ps2_clk = 1'b1;
  endtask

  // Outcome follows the frame rules: stop=0 -> frame error, odd parity -> byte, else parity error.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      fall_edge(bits[i]);
      if (i == 10) begin
        if (!stop)                expect_ev(last_fall + LAT, 1'b0, 1'b0, 1'b1, 1'b0, b);
        else if ((^b ^ par) == 1) expect_ev(last_fall + LAT, 1'b1, 1'b0, 1'b0, b == 8'hAA, b);
        else                      expect_ev(last_fall + LAT, 1'b0, 1'b1, 1'b0, 1'b0, b);
      end
      rise_edge();
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      fall_edge(bits[i]);
      rise_edge();
    end
  endtask

  initial begin
    tick(3);
    chk("reset_data", data, 8'h00);
    rst = 1'b1;
    tick(5);

    send_frame(8'h1C, 1'b0, 1'b1);
    tick(2);
    chk("lit_data_1c", data, 8'h1C);
    chk_int("lit_rr_after_1c", cnt_rr, 0);

    send_frame(8'hAA, 1'b1, 1'b1);
    tick(2);
    chk("lit_data_aa", data, 8'hAA);
    chk_int("lit_rr_after_aa", cnt_rr, 1);

    send_frame(8'h1C, 1'b1, 1'b1);
    tick(2);
    chk("lit_data_kept", data, 8'hAA);
    chk_int("lit_pe_count", cnt_pe, 1);

    send_frame(8'h3C, 1'b1, 1'b0);

    fall_edge(1'b1);
    expect_ev(last_fall + LAT, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    rise_edge();

    send_partial(8'h0F, 5);
    expect_ev(last_fall + LAT + T, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(T + LAT + 20);
    chk_int("lit_fe_count", cnt_fe, 3);
    send_frame(8'h2A, 1'b0, 1'b1);
    tick(2);
    chk("lit_data_2a", data, 8'h2A);

    send_partial(8'h33, 5);
    inhibit = 1'b1;
    ps2_clk = 1'b0;
    tick(30);
    ps2_clk = 1'b1;
    tick(10);
    inhibit = 1'b0;
    tick(T + 20);
    chk_int("lit_fe_after_inhibit", cnt_fe, 3);
    send_frame(8'h55, 1'b1, 1'b1);
    tick(2);
    chk("lit_data_55", data, 8'h55);

    send_partial(8'h81, 3);
    fall_edge(1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_data", data, 8'h00);
    chk("async_rst_strobes", {4'b0, data_valid, parity_err, frame_err, reset_required}, 8'h00);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(10);
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(2);
    chk("lit_data_5a", data, 8'h5A);

    tick(20);
    chk_int("lit_dv_total", cnt_dv, 5);
    chk_int("lit_fe_total", cnt_fe, 3);
    chk_int("pending_events", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
